// File: rtl/ps2_note_pkg.sv
// ps2_note_pkg: shared types and constants for the PS/2 note decoder.
//   - rx_state_e   : receiver FSM state
//   - Sc*          : scancode constants (prefixes, note keys, octave keys)
//   - note_lookup(): maps a scancode to its semitone offset within the octave
package ps2_note_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic [7:0] ScBreak = 8'hF0;
    localparam logic [7:0] ScExt   = 8'hE0;

    // Note keys, lowest to highest semitone.
    localparam logic [7:0] ScA = 8'h1C;
    localparam logic [7:0] ScW = 8'h1D;
    localparam logic [7:0] ScS = 8'h1B;
    localparam logic [7:0] ScE = 8'h24;
    localparam logic [7:0] ScD = 8'h23;
    localparam logic [7:0] ScF = 8'h2B;
    localparam logic [7:0] ScT = 8'h2C;
    localparam logic [7:0] ScG = 8'h34;
    localparam logic [7:0] ScY = 8'h35;
    localparam logic [7:0] ScH = 8'h33;
    localparam logic [7:0] ScU = 8'h3C;
    localparam logic [7:0] ScJ = 8'h3B;
    localparam logic [7:0] ScK = 8'h42;

    // Octave down / up.
    localparam logic [7:0] ScZ = 8'h1A;
    localparam logic [7:0] ScX = 8'h22;

    localparam logic [2:0] OctaveMax = 3'd7;

    typedef struct packed {
        logic       valid;
        logic [3:0] offset;
    } note_lut_t;

    function automatic note_lut_t note_lookup(input logic [7:0] code);
        note_lut_t r;
        r.valid  = 1'b1;
        r.offset = 4'd0;
        case (code)
            ScA:     r.offset = 4'd0;
            ScW:     r.offset = 4'd1;
            ScS:     r.offset = 4'd2;
            ScE:     r.offset = 4'd3;
            ScD:     r.offset = 4'd4;
            ScF:     r.offset = 4'd5;
            ScT:     r.offset = 4'd6;
            ScG:     r.offset = 4'd7;
            ScY:     r.offset = 4'd8;
            ScH:     r.offset = 4'd9;
            ScU:     r.offset = 4'd10;
            ScJ:     r.offset = 4'd11;
            ScK:     r.offset = 4'd12;
            default: r.valid  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Synchronises ps2_clk/ps2_data, glitch-filters the clock, samples data on
// accepted falling edges and checks start/parity/stop. Aborts a frame that
// stalls for TIMEOUT_CYCLES.
// Ports:
//   clk_i, reset_i    : system clock, async active-high reset
//   ps2_clk_i         : raw PS/2 clock (asynchronous)
//   ps2_data_i        : raw PS/2 data (asynchronous)
//   rx_byte_o [7:0]   : received byte, valid while rx_valid_o is high
//   rx_valid_o        : one-cycle strobe for a good frame
//   frame_err_o       : one-cycle strobe for parity/stop error or timeout
module ps2_rx
    import ps2_note_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FltW-1:0] FltMax = FltW'(FILTER_LEN - 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_filt_q, clk_filt_d;
    logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
    logic            fall_edge;

    rx_state_e       state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;

    logic            data_s;
    logic            par_ok;
    logic            tmo_hit;

    assign data_s  = data_sync_q[1];
    // Odd parity across the 8 data bits and the parity bit itself.
    assign par_ok  = ^{shift_q, data_s};
    assign tmo_hit = (state_q != StIdle) && !fall_edge && (tmo_q == TmoMax);

    // Glitch filter: a new level must be seen FILTER_LEN cycles in a row.
    always_comb begin
        clk_filt_d = clk_filt_q;
        flt_cnt_d  = '0;
        fall_edge  = 1'b0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (flt_cnt_q == FltMax) begin
                clk_filt_d = clk_sync_q[1];
                fall_edge  = ~clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FltW'(1);
            end
        end
    end

    // Receiver next state.
    always_comb begin
        state_d = state_q;
        if (fall_edge) begin
            unique case (state_q)
                StIdle:   if (!data_s) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = par_ok ? StStop : StIdle;
                StStop:   state_d = StIdle;
            endcase
        end else if (tmo_hit) begin
            state_d = StIdle;
        end
    end

    // Receiver datapath and strobes.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        tmo_d       = (state_q == StIdle || fall_edge) ? '0 : tmo_q + TmoW'(1);
        if (fall_edge) begin
            unique case (state_q)
                StIdle: bit_cnt_d = 3'd0;
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                StParity: frame_err_d = ~par_ok;
                StStop: begin
                    rx_valid_d  = data_s;
                    frame_err_d = ~data_s;
                end
            endcase
        end else if (tmo_hit) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // Idle PS/2 lines are high.
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            flt_cnt_q   <= '0;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            tmo_q       <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_filt_q  <= clk_filt_d;
            flt_cnt_q   <= flt_cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_byte_o   = shift_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: PS/2 keyboard to note-word front end for the note PIO.
// Tracks break/extended prefixes and an octave register, maps note keys to a
// semitone index and holds the current note word.
// Ports:
//   clk_i, reset_i     : system clock, async active-high reset
//   ps2_clk_i          : raw PS/2 clock
//   ps2_data_i         : raw PS/2 data
//   note_word_o [31:0] : {gate, 24'b0, index[6:0]}, feeds PIO in_port
//   key_event_o        : one-cycle pulse when note_word_o changes
//   frame_err_o        : one-cycle pulse on a bad or timed-out frame
module ps2_note_decoder
    import ps2_note_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned RESET_OCTAVE   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [31:0] note_word_o,
    output logic        key_event_o,
    output logic        frame_err_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) u_rx (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .frame_err_o(rx_err)
    );

    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic [2:0] oct_q, oct_d;
    logic [7:0] cur_key_q, cur_key_d;
    logic       gate_q, gate_d;
    logic [6:0] idx_q, idx_d;
    logic       key_event_q, key_event_d;
    note_lut_t  lut;

    assign lut = note_lookup(rx_byte);

    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        oct_d     = oct_q;
        cur_key_d = cur_key_q;
        gate_d    = gate_q;
        idx_d     = idx_q;
        if (rx_err) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == ScBreak) begin
                brk_d = 1'b1;
            end else if (rx_byte == ScExt) begin
                ext_d = 1'b1;
            end else begin
                // Any non-prefix byte consumes both flags; extended codes are dropped.
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (!ext_q) begin
                    if (lut.valid) begin
                        if (!brk_q) begin
                            idx_d     = 7'(oct_q) * 7'd12 + 7'(lut.offset);
                            gate_d    = 1'b1;
                            cur_key_d = rx_byte;
                        end else if (rx_byte == cur_key_q) begin
                            gate_d = 1'b0;
                        end
                    end else if (!brk_q && rx_byte == ScZ) begin
                        if (oct_q != 3'd0) oct_d = oct_q - 3'd1;
                    end else if (!brk_q && rx_byte == ScX) begin
                        if (oct_q != OctaveMax) oct_d = oct_q + 3'd1;
                    end
                end
            end
        end
        // Typematic repeats leave the word unchanged and so raise no event.
        key_event_d = (gate_d != gate_q) || (idx_d != idx_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            oct_q       <= 3'(RESET_OCTAVE);
            cur_key_q   <= 8'h00;
            gate_q      <= 1'b0;
            idx_q       <= 7'd0;
            key_event_q <= 1'b0;
        end else begin
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            oct_q       <= oct_d;
            cur_key_q   <= cur_key_d;
            gate_q      <= gate_d;
            idx_q       <= idx_d;
            key_event_q <= key_event_d;
        end
    end

    assign note_word_o = {gate_q, 24'd0, idx_q};
    assign key_event_o = key_event_q;
    assign frame_err_o = rx_err;

endmodule

// File: tb/tb_ps2_note_decoder.sv
module tb_ps2_note_decoder;

    localparam int Half = 10;  // PS/2 clock half period in system clocks

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] note_word;
    logic        key_event;
    logic        frame_err;

    ps2_note_decoder dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .note_word_o(note_word),
        .key_event_o(key_event),
        .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    int ev_cnt  = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (key_event) ev_cnt <= ev_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: keyboard state as described by the key rules.
    logic [7:0] note_codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                   8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
    int         m_oct;
    bit         m_gate;
    int         m_idx;
    logic [7:0] m_cur;
    bit         m_brk;
    bit         m_ext;

    function automatic int find_note(input logic [7:0] b);
        for (int i = 0; i < 13; i++) if (note_codes[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_word();
        logic [6:0] ix;
        ix = 7'(m_idx);
        return {m_gate, 24'd0, ix};
    endfunction

    task automatic model_reset();
        m_oct = 4; m_gate = 0; m_idx = 0; m_cur = 8'h00; m_brk = 0; m_ext = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int off;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            off = find_note(b);
            if (!m_ext) begin
                if (off >= 0) begin
                    if (!m_brk) begin
                        m_idx = 12 * m_oct + off; m_gate = 1; m_cur = b;
                    end else if (b == m_cur) m_gate = 0;
                end else if (!m_brk && b == 8'h1A) begin
                    if (m_oct > 0) m_oct--;
                end else if (!m_brk && b == 8'h22) begin
                    if (m_oct < 7) m_oct++;
                end
            end
            m_brk = 0; m_ext = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    // Drives the first nbits bits of a frame: start, 8 data LSB first, parity, stop.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (Half) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (Half) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input string tag);
        int          ev0, er0;
        logic [31:0] old;
        bit          bad;
        ev0 = ev_cnt; er0 = err_cnt; old = m_word();
        bad = bad_par | bad_stop;
        send_frame(b, bad_par, bad_stop, 11);
        repeat (30) @(posedge clk);
        #1;
        if (bad) begin
            m_brk = 0; m_ext = 0;
        end else begin
            model_byte(b);
        end
        check({tag, "/word"}, note_word, m_word());
        check({tag, "/event"}, 32'(ev_cnt - ev0), {31'd0, m_word() != old});
        check({tag, "/err"}, 32'(err_cnt - er0), {31'd0, bad});
    endtask

    initial begin
        int er0, n, r;
        logic [7:0] b;
        bit bp, bs;

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        do_reset();

        // Reset state.
        check("rst_word", note_word, 32'h0000_0000);
        check("rst_event", {31'd0, key_event}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_counts", 32'(ev_cnt + err_cnt), 32'd0);

        // Make, then break of the same key.
        xfer(8'h1C, 0, 0, "make_a");
        check("make_a_val", note_word, 32'h8000_0030);
        xfer(8'h1C, 0, 0, "typematic");
        xfer(8'hF0, 0, 0, "brk_pfx");
        xfer(8'h1C, 0, 0, "brk_a");
        check("brk_a_val", note_word, 32'h0000_0030);

        // Break of a non-current key is ignored.
        xfer(8'h1C, 0, 0, "m1c");
        xfer(8'h23, 0, 0, "m23");
        xfer(8'hF0, 0, 0, "f0");
        xfer(8'h1C, 0, 0, "b1c");
        check("other_brk_val", note_word, 32'h8000_0034);

        // Octave up, then S.
        xfer(8'h22, 0, 0, "oct_up");
        check("oct_up_no_repitch", note_word, 32'h8000_0034);
        xfer(8'h1B, 0, 0, "make_s");
        check("make_s_val", note_word, 32'h8000_003E);

        // Octave saturation at 0.
        do_reset();
        for (int i = 0; i < 6; i++) xfer(8'h1A, 0, 0, "oct_dn");
        xfer(8'h1C, 0, 0, "make_a_oct0");
        check("oct0_val", note_word, 32'h8000_0000);

        // Bad parity and bad stop.
        xfer(8'h1C, 0, 0, "pre_err");
        xfer(8'h1D, 1, 0, "bad_par");
        check("bad_par_val", note_word, 32'h8000_0000);
        xfer(8'h1D, 0, 1, "bad_stop");

        // Extended code is ignored.
        xfer(8'hE0, 0, 0, "ext_pfx");
        xfer(8'h24, 0, 0, "ext_e");
        check("ext_val", note_word, 32'h8000_0000);

        // Abandoned frame times out after ~TIMEOUT_CYCLES.
        send_frame(8'h1C, 0, 0, 4);
        er0 = err_cnt; n = 0;
        while (err_cnt == er0 && n < 52000) begin
            @(posedge clk);
            n++;
        end
        #1;
        m_brk = 0; m_ext = 0;
        check("tmo_fired", 32'(err_cnt - er0), 32'd1);
        check("tmo_window", {31'd0, (n >= 49900 && n <= 50100)}, 32'd1);
        check("tmo_word", note_word, m_word());
        xfer(8'h1D, 0, 0, "after_tmo");

        // Asynchronous reset mid-frame.
        send_frame(8'h1C, 0, 0, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_word", note_word, 32'h0000_0000);
        @(posedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        xfer(8'h1C, 0, 0, "post_rst");
        check("post_rst_val", note_word, 32'h8000_0030);

        // Random traffic against the model.
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 19);
            if (r <= 8) b = note_codes[$urandom_range(0, 12)];
            else if (r <= 11) b = 8'hF0;
            else if (r == 12) b = 8'hE0;
            else if (r == 13) b = 8'h1A;
            else if (r == 14) b = 8'h22;
            else b = 8'($urandom_range(0, 255));
            r  = $urandom_range(0, 31);
            bp = (r == 0);
            bs = (r == 1);
            xfer(b, bp, bs, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_note_decoder.md
# ps2_note_decoder

Upstream front end of the note-index input PIO. Receives PS/2 keyboard frames, tracks make/break/extended prefixes and an octave register, and maps a fixed set of keys to a semitone index. The result is presented as a 32-bit note word that drives the PIO `in_port` directly, so the Nios CPU reads the currently held note with one register read.

## Interface
- `TIMEOUT_CYCLES`, 50000: clk cycles with no PS/2 falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
- `FILTER_LEN`, 8: clk cycles the synchronised `ps2_clk` must hold a new level before the edge is accepted.
- `RESET_OCTAVE`, 4: octave register value after reset, range 0..7.

- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `note_word` out 32: bit 31 is gate (key held), bits 30:7 are zero, bits 6:0 are the note index. Feeds PIO `in_port`.
- `key_event` out 1: one-cycle pulse whenever `note_word` changes.
- `frame_err` out 1: one-cycle pulse on a parity error, a bad stop bit, or a timeout.

## Operation
- **Input conditioning.** `ps2_clk` and `ps2_data` pass through 2-FF synchronisers. `ps2_clk` is then glitch-filtered with a `FILTER_LEN` counter. An accepted falling edge samples the synchronised data.
- **Receiver FSM.**
  - IDLE → DATA when a start bit (0) is sampled. A sampled 1 stays in IDLE.
  - DATA: 8 bits, LSB first, then → PARITY.
  - PARITY: requires odd parity over the 8 data bits plus the parity bit, then → STOP.
  - STOP: requires 1, then emits the byte and returns → IDLE.
- **Frame errors.** Any check failure, or `TIMEOUT_CYCLES` without an edge in a non-IDLE state, does three things:
  - goes to IDLE;
  - pulses `frame_err`;
  - discards the byte and clears the break/extended flags.
- **Prefix bytes.**
  - 0xF0 sets `brk`.
  - 0xE0 sets `ext`.
  - Any other byte consumes both flags.
- **Extended codes.** Any byte with `ext` set is ignored (no state change).
- **Note keys**, offsets 0..12:
  - 0x1C A→0, 0x1D W→1, 0x1B S→2, 0x24 E→3, 0x23 D→4
  - 0x2B F→5, 0x2C T→6, 0x34 G→7, 0x35 Y→8, 0x33 H→9
  - 0x3C U→10, 0x3B J→11, 0x42 K→12
- **Make of a note key:**
  - index = 12×octave + offset (max 96, fits 7 bits);
  - gate = 1;
  - `cur_key` = scancode.
  - A typematic repeat that produces the identical word causes no `key_event`.
- **Break of a note key:**
  - if the scancode equals `cur_key`: gate = 0 and the index is retained;
  - otherwise the break is ignored.
- **Octave keys** (make only):
  - 0x1A Z decrements the octave, saturating at 0.
  - 0x22 X increments the octave, saturating at 7.
  - A held note is not re-pitched.
- **Other scancodes** are ignored.
- **Reset values:**
  - `note_word` = 0x0000_0000;
  - `key_event` = 0, `frame_err` = 0;
  - octave = `RESET_OCTAVE`, `cur_key` = 0x00;
  - FSM in IDLE, flags clear.

## Timing
- Latency: `note_word` and `key_event` update on the clk edge one cycle after the receiver's byte-valid strobe. The strobe occurs one cycle after the accepted STOP edge.
- Edge acceptance latency: 2 synchroniser cycles + `FILTER_LEN` cycles after the raw edge.
- Byte-valid and `frame_err` are mutually exclusive; at most one pulses per frame.
- `reset` asserted mid-frame: all state returns to its reset value immediately (asynchronous). The partial frame is lost, and the next start bit begins a clean frame.
- The timeout counter clears on every accepted edge and is held at zero in IDLE.

## Structure
- **Shared package** (`ps2_note_pkg`):
  - receiver state enum (IDLE, DATA, PARITY, STOP);
  - scancode constants (0xF0, 0xE0, note keys, Z/X);
  - the offset lookup function.
- **Sub-module `ps2_rx`**: synchronisers, filter, receiver FSM and timeout. Outputs `rx_byte[7:0]`, `rx_valid`, `frame_err`.
- **Top level**: prefix tracking, key map, octave register and output register.

## Test plan
- Reset → `note_word` = 0x0000_0000, no pulses. Make 0x1C → `note_word` = 0x8000_0030 with one `key_event`.
- Sequence 0x1C, F0 1C → 0x8000_0030, then 0x0000_0030.
- Make 0x1C, make 0x23, break 0x1C → 0x8000_0034 remains, because a break of a non-current key is ignored.
- X, then 0x1B → octave 5, `note_word` = 0x8000_003E.
- Z pressed 6 times from reset, then 0x1C → octave saturates at 0, `note_word` = 0x8000_0000, with `key_event` firing on the 0x1C make.
- Error cases:
  - Frame 0x1C with a bad parity bit → `frame_err` pulse, `note_word` unchanged.
  - Frame abandoned after 4 bits, then 50000 idle cycles → `frame_err` pulse.
  - E0 1C → no change.
